// File: rtl/nibble_divider_seq_if.sv
// Operand/result bundle for the sequential nibble divider.
// The master drives start and the operands; the slave returns status and results.
interface nibble_divider_seq_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/nibble_divider_seq.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
// A zero divisor short-circuits to all-ones quotient and the dividend as remainder.
module nibble_divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  nibble_divider_seq_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pr;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_q;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  // Shifted partial remainder is kept at WIDTH+1 bits: its top bit can be set
  // when the divisor is large, and the borrow of the subtraction lands in bit WIDTH.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_pr_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_shift   = {r_pr, r_dvd[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dsr};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_pr_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_q_next  = {r_q[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pr    <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              r_quot <= '1;
              r_rem  <= bus.dividend;
              r_dbz  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_dvd   <= bus.dividend;
              r_dsr   <= bus.divisor;
              r_pr    <= '0;
              r_q     <= '0;
              r_cnt   <= LAST;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_pr  <= w_pr_next;
          r_q   <= w_q_next;
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          if (r_cnt == '0) begin
            r_quot  <= w_q_next;
            r_rem   <= w_pr_next;
            r_dbz   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state == RUN);
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_nibble_divider_seq.sv
// Self-checking bench for nibble_divider_seq: vector table, random vectors,
// and hand-written busy/back-to-back/reset sequences with a result scoreboard.
module tb_nibble_divider_seq;
  logic clk;
  logic reset;

  nibble_divider_seq_if #(.WIDTH(4)) bus ();

  nibble_divider_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  typedef struct {
    logic [3:0] dvd;
    logic [3:0] dsr;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Result scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", int'(bus.quotient), int'(e.q));
        chk("remainder", int'(bus.remainder), int'(e.r));
        chk("div_by_zero", int'(bus.div_by_zero), int'(e.dbz));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [3:0] dvd, input logic [3:0] dsr,
                       input logic [3:0] q, input logic [3:0] r, input logic dbz);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz;
    exp_q.push_back(e);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dsr;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = $urandom_range(15);
    bus.divisor  = $urandom_range(15);
  endtask

  // Counts negedges without done from the current one; returns at the done negedge.
  task automatic wait_done(input int exp_lat, input int exp_busy);
    int lat   = 0;
    int nbusy = 0;
    bit seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) nbusy++;
      lat++;
      @(negedge clk);
    end
    chk("done_seen", int'(seen), 1);
    if (seen) begin
      chk("latency", lat, exp_lat);
      chk("busy_cycles", nbusy, exp_busy);
      chk("busy_in_done", int'(bus.busy), 0);
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{dvd: 4'd13, dsr: 4'd4,  q: 4'd3,  r: 4'd1, dbz: 1'b0};
    tbl[1] = '{dvd: 4'd15, dsr: 4'd1,  q: 4'd15, r: 4'd0, dbz: 1'b0};
    tbl[2] = '{dvd: 4'd0,  dsr: 4'd5,  q: 4'd0,  r: 4'd0, dbz: 1'b0};
    tbl[3] = '{dvd: 4'd3,  dsr: 4'd7,  q: 4'd0,  r: 4'd3, dbz: 1'b0};
    tbl[4] = '{dvd: 4'd15, dsr: 4'd15, q: 4'd1,  r: 4'd0, dbz: 1'b0};
    tbl[5] = '{dvd: 4'd9,  dsr: 4'd0,  q: 4'hF,  r: 4'd9, dbz: 1'b1};
    tbl[6] = '{dvd: 4'd8,  dsr: 4'd2,  q: 4'd4,  r: 4'd0, dbz: 1'b0};
    tbl[7] = '{dvd: 4'd14, dsr: 4'd9,  q: 4'd1,  r: 4'd5, dbz: 1'b0};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_quotient", int'(bus.quotient), 0);
    chk("rst_remainder", int'(bus.remainder), 0);
    chk("rst_dbz", int'(bus.div_by_zero), 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      issue(tbl[i].dvd, tbl[i].dsr, tbl[i].q, tbl[i].r, tbl[i].dbz);
      wait_done((tbl[i].dsr == 4'd0) ? 0 : 4, (tbl[i].dsr == 4'd0) ? 0 : 4);
      @(negedge clk);
    end

    for (int i = 0; i < 12; i++) begin
      logic [3:0] a;
      logic [3:0] b;
      a = 4'($urandom_range(15));
      b = 4'($urandom_range(15));
      if (b == 4'd0) issue(a, b, 4'hF, a, 1'b1);
      else           issue(a, b, a / b, a % b, 1'b0);
      wait_done((b == 4'd0) ? 0 : 4, (b == 4'd0) ? 0 : 4);
      @(negedge clk);
    end

    // Start on the 2nd busy cycle must be ignored.
    issue(4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd6;
    bus.divisor  = 4'd3;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_done(2, 2);
    repeat (6) @(negedge clk);

    // Back-to-back: start accepted in the done cycle, old results held meanwhile.
    issue(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);
    wait_done(4, 4);
    issue(4'd10, 4'd5, 4'd2, 4'd0, 1'b0);
    chk("held_quotient", int'(bus.quotient), 4);
    chk("held_remainder", int'(bus.remainder), 2);
    chk("busy_after_b2b", int'(bus.busy), 1);
    wait_done(4, 4);
    @(negedge clk);

    // Reset on the 3rd busy cycle aborts with no done.
    issue(4'd13, 4'd4, 4'd3, 4'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_quotient", int'(bus.quotient), 0);
    chk("abort_remainder", int'(bus.remainder), 0);
    chk("abort_dbz", int'(bus.div_by_zero), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_idle_busy", int'(bus.busy), 0);
    issue(4'd7, 4'd2, 4'd3, 4'd1, 1'b0);
    wait_done(4, 4);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
